// File: rtl/sr_latch_driver.sv
// Stimulus side of an SR latch: non-overlapping timed S/R pulses,
// a guard interval, then a synchronised Q/Qbar feedback check.
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int GUARD_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic q_fb,
    input  logic qbar_fb,
    output logic busy,
    output logic done,
    output logic err,
    input  logic err_clr,
    output logic level
);

    localparam int MAXW = (PULSE_W > GUARD_W) ? PULSE_W : GUARD_W;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GUARD,
        CHECK
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          cmd_val;
    logic          cmd_val_nx;
    logic          s_nx;
    logic          r_nx;
    logic          q_s1;
    logic          q_s2;
    logic          qb_s1;
    logic          qb_s2;
    logic          fault;

    // S/R are registered from the next state so they track PULSE exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            cmd_val <= 1'b0;
            S       <= 1'b0;
            R       <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            cmd_val <= cmd_val_nx;
            S       <= s_nx;
            R       <= r_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        cmd_val_nx = cmd_val;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx   = PULSE;
                    cnt_nx     = CW'(PULSE_W - 1);
                    cmd_val_nx = req_val;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nx = GUARD;
                    cnt_nx   = CW'(GUARD_W - 1);
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            GUARD: begin
                if (cnt == '0) begin
                    state_nx = CHECK;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            CHECK: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        s_nx = (state_nx == PULSE) &&  cmd_val_nx;
        r_nx = (state_nx == PULSE) && !cmd_val_nx;
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_s1  <= 1'b0;
            q_s2  <= 1'b0;
            qb_s1 <= 1'b0;
            qb_s2 <= 1'b0;
        end else begin
            q_s1  <= q_fb;
            q_s2  <= q_s1;
            qb_s1 <= qbar_fb;
            qb_s2 <= qb_s1;
        end
    end

    assign fault = (q_s2 != cmd_val) || (q_s2 == qb_s2);

    // A fault seen in CHECK beats a simultaneous err_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            err   <= 1'b0;
            level <= 1'b0;
        end else begin
            if ((state == CHECK) && fault) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
            if ((state == CHECK) && !fault) begin
                level <= cmd_val;
            end
        end
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Synchronous driver for an external or behavioural SR latch: the stimulus end of the S/R interface. It accepts set/clear commands over a valid/ready handshake and issues a timed, non-overlapping S or R pulse. It holds a guard interval, then checks the latch's Q/Qbar feedback. It sits between control logic and any SR storage cell, guarantees the forbidden S=R=1 input is never driven, and flags latch faults.

Parameters:
PULSE_W, 4, cycles S or R is held high per command (>=1)
GUARD_W, 2, cycles both S and R are low after a pulse before feedback is checked (>=2; covers the feedback synchroniser)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  command valid
req_val  input  1  1 = set latch, 0 = clear latch
req_ready  output  1  block can accept a command
S  output  1  set drive to latch (registered)
R  output  1  reset drive to latch (registered)
q_fb  input  1  latch Q feedback (asynchronous)
qbar_fb  input  1  latch Qbar feedback (asynchronous)
busy  output  1  command in progress
done  output  1  one-cycle pulse when a command completes
err  output  1  sticky fault flag
err_clr  input  1  clears err
level  output  1  last successfully written value

Behaviour:
- Reset (rst=1 at an edge): S=0, R=0, req_ready=1, busy=0, done=0, err=0, level=0, state=IDLE, counter=0, synchroniser flops=0. rst overrides every other input.
- Clock and reset are one clock and one reset: clk, rst, synchronous, active-high.
- The feedback inputs q_fb and qbar_fb pass through a 2-flop synchroniser each before any use.
- States: IDLE, PULSE, GUARD, CHECK.
- IDLE: req_ready=1. A command is accepted when req_valid & req_ready at an edge; req_val is latched into cmd_val and the counter is loaded with PULSE_W-1. Next state is PULSE.
- PULSE: S=cmd_val, R=~cmd_val, req_ready=0, busy=1. When counter=0, load GUARD_W-1 and go to GUARD; otherwise decrement.
- GUARD: S=R=0, busy=1. When counter=0, go to CHECK; otherwise decrement.
- CHECK: lasts one cycle with done=1 and busy=1. A fault exists if sync_q != cmd_val or sync_q == sync_qbar. On a fault, err is set and level is unchanged. Otherwise level=cmd_val. Next state is IDLE.
- Timing, with the command accepted at edge k:
  - S or R is high during cycles k+1 .. k+PULSE_W.
  - Guard cycles follow.
  - done is high in cycle k+PULSE_W+GUARD_W+1.
  - req_ready is high again in the following cycle.
- Throughput: one command per PULSE_W+GUARD_W+2 cycles (defaults: 8).
- req_valid while busy is ignored and not queued. The requester must hold req_valid until it sees ready.
- S and R are both driven from registers and are never simultaneously 1 in any cycle, including across reset and state transitions.
- err is sticky:
  - err_clr=1 at an edge clears it, unless CHECK detects a fault in the same cycle, in which case set wins.
  - err does not block further commands.
- Reset mid-operation, in any state: next cycle S=R=0, IDLE, the pending command is discarded, and no done pulse is issued.
- Counter width is clog2 of max(PULSE_W, GUARD_W), minimum 1 bit. No wrap occurs because the counter is reloaded on every state entry.
- A command that re-writes the current level is still fully pulsed and checked.

Test Plan:
1. After rst, req_valid=1, req_val=1, with the feedback driven by a behavioural SR latch model -> S=1 for exactly 4 cycles, R=0 throughout, done in the 7th cycle after accept, level=1, err=0, req_ready=1 in the 8th.
2. Then req_val=0 -> R=1 for 4 cycles, S=0, done after 7 cycles, level=0, Q=0, Qbar=1 on the model.
3. Feedback stuck at q_fb=0, qbar_fb=1 with a set command -> err=1 at the edge after CHECK, level stays 0. A subsequent err_clr pulse -> err=0. err_clr asserted in the same cycle as a faulting CHECK -> err=1.
4. Feedback q_fb=qbar_fb=1, mimicking the forbidden latch state -> err=1 for either command value.
5. req_valid held high continuously with alternating req_val -> accepts exactly 8 cycles apart. Assertion: !(S&R) on every cycle.
6. rst asserted in the 2nd PULSE cycle of a set -> next cycle S=0, req_ready=1, busy=0, no done, level=0. A new command afterwards completes normally.
